// File: rtl/instr_exec_unit.sv
// Multi-cycle executor for a small MIPS subset (ADDIU/ADDU/SUBU) with a 32-entry register file.
// Consumes one issued instruction at a time and exposes OUTPUT_REG once the LAST_PC instruction retires.
module instr_exec_unit #(
    parameter int unsigned OUTPUT_REG = 5,
    parameter int unsigned LAST_PC    = 7,
    parameter int unsigned DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    input  logic [3:0]        pc,
    output logic              done,
    output logic              display_availiable,
    output logic [DATA_W-1:0] value
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [4:0] OREG     = 5'(OUTPUT_REG);
    localparam logic [3:0] FINAL_PC = 4'(LAST_PC);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_DECODE, S_EXEC, S_WB, S_DONE
    } state_t;

    state_t            r_state;
    logic [31:0]       r_instr;
    logic [3:0]        r_pc;
    logic [5:0]        r_opcode;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic [5:0]        r_funct;
    logic [15:0]       r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_we;
    logic [4:0]        r_waddr;
    logic [DATA_W-1:0] r_regs [32];
    logic              r_done;
    logic              r_disp;
    logic [DATA_W-1:0] r_value;

    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_result;
    logic              w_we;
    logic [4:0]        w_waddr;
    logic              w_final;

    assign w_imm   = DATA_W'(r_imm);
    // $0 is hardwired; never trust the array slot even though it is never written
    assign w_rd_a  = (r_rs == 5'd0) ? '0 : r_regs[r_rs];
    assign w_rd_b  = (r_rt == 5'd0) ? '0 : r_regs[r_rt];
    assign w_final = (r_pc == FINAL_PC);

    always_comb begin
        w_result = '0;
        w_we     = 1'b0;
        w_waddr  = r_rd;
        if (r_opcode == OP_ADDIU) begin
            w_result = r_a + w_imm;
            w_waddr  = r_rt;
            w_we     = (r_rt != 5'd0);
        end else if (r_opcode == OP_RTYPE) begin
            if (r_funct == FN_ADDU) begin
                w_result = r_a + r_b;
                w_we     = (r_rd != 5'd0);
            end else if (r_funct == FN_SUBU) begin
                w_result = r_a - r_b;
                w_we     = (r_rd != 5'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_instr  <= '0;
            r_pc     <= '0;
            r_opcode <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_funct  <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_done   <= 1'b0;
            r_disp   <= 1'b0;
            r_value  <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instruction;
                        r_pc    <= pc;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_opcode <= r_instr[31:26];
                    r_rs     <= r_instr[25:21];
                    r_rt     <= r_instr[20:16];
                    r_rd     <= r_instr[15:11];
                    r_funct  <= r_instr[5:0];
                    r_imm    <= r_instr[15:0];
                    r_state  <= S_DECODE;
                end
                S_DECODE: begin
                    r_a     <= w_rd_a;
                    r_b     <= w_rd_b;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= w_result;
                    r_we     <= w_we;
                    r_waddr  <= w_waddr;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    if (r_we) r_regs[r_waddr] <= r_result;
                    // Final snapshot is taken once; the write landing this cycle is forwarded
                    if (w_final && !r_disp) begin
                        r_value <= (r_we && r_waddr == OREG) ? r_result : r_regs[OREG];
                        r_disp  <= 1'b1;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign done               = r_done;
    assign display_availiable = r_disp;
    assign value              = r_value;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: directed program plus randomized programs scored against
// an instruction-level model of the register file and the final-result snapshot.
module tb_instr_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        done;
    logic        disp;
    logic [15:0] value;

    always #5 clk = ~clk;

    instr_exec_unit #(.OUTPUT_REG(5), .LAST_PC(7), .DATA_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instruction       (instruction),
        .instr_valid       (instr_valid),
        .pc                (pc),
        .done              (done),
        .display_availiable(disp),
        .value             (value)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_r [32];
    logic        m_disp;
    logic [15:0] m_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_r[i] = 16'h0;
        m_disp = 1'b0;
        m_val  = 16'h0;
    endtask

    // Architectural effect of one instruction, straight from the ISA rules
    task automatic model_exec(input logic [31:0] ins, input logic [3:0] p);
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
        if (op == 6'h09) begin
            if (rt != 0) m_r[rt] = m_r[rs] + ins[15:0];
        end else if (op == 6'h00 && fn == 6'h21) begin
            if (rd != 0) m_r[rd] = m_r[rs] + m_r[rt];
        end else if (op == 6'h00 && fn == 6'h23) begin
            if (rd != 0) m_r[rd] = m_r[rs] - m_r[rt];
        end
        if (p == 4'd7 && !m_disp) begin
            m_disp = 1'b1;
            m_val  = m_r[5];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // Issue one instruction while the DUT is idle; garbage is driven on the inputs while busy
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] p);
        logic old_disp;
        old_disp    = m_disp;
        instruction = ins;
        pc          = p;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        model_exec(ins, p);
        for (int k = 1; k <= 5; k++) begin
            instruction = $urandom;
            pc          = 4'($urandom);
            instr_valid = 1'($urandom);
            @(posedge clk); #1;
            chk($sformatf("done_k%0d", k), {31'd0, done}, {31'd0, k == 4});
            if (k == 3) chk("disp_before_done", {31'd0, disp}, {31'd0, old_disp});
            if (k == 4) begin
                chk("disp", {31'd0, disp}, {31'd0, m_disp});
                chk("value", {16'd0, value}, {16'd0, m_val});
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_r%0d", tag, i), {16'd0, dut.r_regs[i]}, {16'd0, m_r[i]});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        logic [5:0] op, fn;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 4))
            0: return {6'h09, rs, rt, 16'($urandom)};
            1: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            2: return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            3: begin
                op = 6'($urandom_range(1, 63));
                if (op == 6'h09) op = 6'h0A;
                return {op, rs, rt, 16'($urandom)};
            end
            default: begin
                fn = 6'($urandom);
                if (fn == 6'h21 || fn == 6'h23) fn = 6'h20;
                return {6'h00, rs, rt, rd, 5'd0, fn};
            end
        endcase
    endfunction

    function automatic logic [3:0] rand_pc_not_final();
        logic [3:0] p;
        p = 4'($urandom);
        if (p == 4'd7) p = 4'd8;
        return p;
    endfunction

    logic [31:0] prog [7];

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instruction = 32'h0; pc = 4'h0;
        do_reset();

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("idle_done", {31'd0, done}, 32'd0);
            chk("idle_disp", {31'd0, disp}, 32'd0);
            chk("idle_value", {16'd0, value}, 32'd0);
        end

        // Reference program
        prog = '{32'h2401002d, 32'h2402ffec, 32'h2403ffc4, 32'h2404001e,
                 32'h00222821, 32'h00643021, 32'h00a62823};
        for (int i = 0; i < 7; i++) run_instr(prog[i], 4'(i + 1));
        chk("prog_R1", {16'd0, dut.r_regs[1]}, 32'd45);
        chk("prog_R2", {16'd0, dut.r_regs[2]}, 32'h0000FFEC);
        chk("prog_R5", {16'd0, dut.r_regs[5]}, 32'd55);
        chk("prog_R6", {16'd0, dut.r_regs[6]}, 32'h0000FFE2);
        chk("prog_value", {16'd0, value}, 32'h00000037);
        chk("prog_disp", {31'd0, disp}, 32'd1);
        chk_regs("prog");

        // Wrap-around, $0 writes, illegal opcode
        do_reset();
        run_instr(32'h24017fff, 4'd1);
        run_instr(32'h24210001, 4'd2);
        chk("wrap_add", {16'd0, dut.r_regs[1]}, 32'h00008000);
        run_instr(32'h00010823, 4'd3);
        chk("wrap_sub", {16'd0, dut.r_regs[1]}, 32'h00008000);
        run_instr(32'h2400ffff, 4'd4);
        run_instr(32'h00001021, 4'd5);
        chk("r0_write_R0", {16'd0, dut.r_regs[0]}, 32'd0);
        chk("r0_write_R2", {16'd0, dut.r_regs[2]}, 32'd0);
        run_instr(32'hFC000000, 4'd6);
        chk_regs("illegal");

        // Reset while in EXEC aborts the instruction
        do_reset();
        instruction = 32'h2401002d; pc = 4'd1; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_exec_done", {31'd0, done}, 32'd0);
        chk("rst_exec_R1", {16'd0, dut.r_regs[1]}, 32'd0);
        rst_n = 1'b1;
        model_reset();
        run_instr(32'h00202821, 4'd7);
        chk("rst_exec_value", {16'd0, value}, 32'd0);

        // Randomized programs, including instructions after the final one
        for (int r = 0; r < 6; r++) begin
            int n;
            do_reset();
            n = $urandom_range(3, 10);
            for (int j = 0; j < n; j++) run_instr(rand_instr(), rand_pc_not_final());
            run_instr((r % 2 == 0) ? {6'h00, 5'($urandom_range(1, 7)), 5'($urandom_range(0, 7)),
                                      5'd5, 5'd0, 6'h21} : rand_instr(), 4'd7);
            chk_regs($sformatf("rnd%0d_final", r));
            run_instr(rand_instr(), 4'd7);
            run_instr(rand_instr(), rand_pc_not_final());
            chk_regs($sformatf("rnd%0d_post", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
